pixel_mem_bank_array: RTL and testbench
=======================================

Name: pixel_mem_bank_array

Overview:
Parametrised multi-bank pixel line-buffer memory for the ISP pixel path. It replaces the fixed two-bank wrapper with NUM_BANKS independent single-port banks of configurable depth and width. Each bank has a request/grant front end, a read-valid pipeline and an optional output register. A built-in zero-fill sweep clears all banks after reset or on request, so downstream line filters never read stale frame data.

Parameters:
- NUM_BANKS, 2, number of independent line-buffer banks (1..8)
- ADDR_WIDTH, 8, bank address width; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width; must be a multiple of 8
- OUT_REG, 0, 1 adds a read-data output register (read latency 2 instead of 1)

Ports:
- pixel_clk_i  in  1  pixel clock, sole clock
- reset_n_i  in  1  asynchronous active-low reset
- init_req_i  in  1  pulse: start a zero-fill sweep of all banks
- init_busy_o  out  1  high while a sweep runs
- req_i  in  [NUM_BANKS]x1  per-bank access request
- we_i  in  [NUM_BANKS]x1  1=write, 0=read; valid with req_i
- be_i  in  [NUM_BANKS]x(DATA_WIDTH/8)  active-high byte enables for writes
- addr_i  in  [NUM_BANKS]xADDR_WIDTH  word address
- wdata_i  in  [NUM_BANKS]xDATA_WIDTH  write data
- gnt_o  out  [NUM_BANKS]x1  access accepted this cycle (combinational)
- rvalid_o  out  [NUM_BANKS]x1  rdata_o valid for an earlier granted read
- rdata_o  out  [NUM_BANKS]xDATA_WIDTH  read data

Behaviour:
- One clock, pixel_clk_i. reset_n_i is asynchronous, active-low. All state uses async assert and sync-to-clock deassert.
- Reset values:
  - init_busy_o=1 (the sweep starts automatically)
  - gnt_o=0, rvalid_o=0, rdata_o=0
  - memory contents undefined until the sweep completes
- FSM states: CLEAR, READY.
  - Reset enters CLEAR with the sweep counter at 0.
  - CLEAR: every cycle, write all-zero with full byte enables at address cnt in all banks simultaneously, then cnt++. After address 2**ADDR_WIDTH-1 is written, go to READY. The sweep takes exactly 2**ADDR_WIDTH cycles.
  - READY: when init_req_i=1, go to CLEAR and reset cnt to 0.
- init_busy_o = (state==CLEAR), registered.
- init_req_i is ignored while in CLEAR; the sweep is not restarted.
- gnt_o[b] = req_i[b] && state==READY. Requests during CLEAR are not granted or queued; the requester holds req_i until granted.
- Write (granted, we_i=1):
  - Bytes with be_i=1 are updated at the next clock edge; other bytes are unchanged.
  - be_i=0 is a legal no-op.
  - No rvalid_o is produced.
- Read (granted, we_i=0):
  - OUT_REG=0: rdata_o/rvalid_o appear 1 cycle after the grant.
  - OUT_REG=1: rdata_o/rvalid_o appear 2 cycles after the grant.
  - Reads are fully pipelined: a new read may be granted every cycle.
- rvalid_o is a single-cycle pulse per read. rdata_o holds its last value when rvalid_o=0.
- Each bank is single-port, so one operation per bank per cycle. A read in cycle N+1 of an address written in cycle N returns the new data.
- Banks are fully independent; simultaneous accesses to different banks never interact.
- If init_req_i is accepted while reads are in flight, those reads still complete with pre-sweep data.
- Reset mid-sweep or mid-read aborts everything: pipelines are flushed, rvalid_o=0, and the sweep restarts from 0 after release.
- Sweep counter width is ADDR_WIDTH+1 so the terminal count is detected without wrap. The address port always covers the full depth, so there is no out-of-range case.

Decomposition:
- Package pixel_mem_pkg:
  - FSM state enum (CLEAR, READY)
  - function computing byte-enable width
  - default parameter constants
- Sub-module pixel_mem_bank: one single-port byte-enabled array with 1-cycle registered read and optional output register. It is instantiated NUM_BANKS times in a generate loop.
- The top level holds the FSM, sweep counter, grant logic, and the mux between sweep writes and user access.

Test Plan:
1. Reset release, then poll → init_busy_o high for exactly 256 cycles (ADDR_WIDTH=8); then read bank0 addr 0x00 and 0xFF → rdata 0x00000000 one cycle after grant.
2. Write bank1 addr 0x10 data 0xDEADBEEF be=4'b1111, then write 0x11223344 with be=4'b0101, then read → 0xDE22BE44 with rvalid one cycle later (two cycles with OUT_REG=1).
3. Back-to-back reads of addr 0..3 in bank0 after writing 0xA0..0xA3 → four consecutive rvalid pulses with data 0xA0,0xA1,0xA2,0xA3.
4. Pulse init_req_i after filling bank0 with 0x55555555 → gnt_o stays 0 on held requests for 256 cycles; afterwards reads return 0.
5. Assert reset_n_i low at sweep cycle 100 → outputs return to reset values immediately; after release the sweep lasts a full 256 cycles.
6. NUM_BANKS=4: same-cycle write in bank2 and read in bank3 of the same address → no interaction; bank3 returns its own data.

Source files
------------

// File: rtl/pixel_mem_pkg.sv
// Shared types and defaults for the multi-bank pixel line-buffer memory.
package pixel_mem_pkg;

  localparam int DEF_NUM_BANKS  = 2;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_OUT_REG    = 0;

  typedef enum logic {
    CLEAR,
    READY
  } mem_state_e;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/pixel_mem_bank.sv
// One single-port byte-enabled line-buffer bank with registered read
// and an optional extra output register.
module pixel_mem_bank
  import pixel_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_REG    = DEF_OUT_REG
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              we,
  input  logic [be_width(DATA_WIDTH)-1:0]   be,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic [DATA_WIDTH-1:0]             wdata,
  output logic                              rvalid,
  output logic [DATA_WIDTH-1:0]             rdata
);

  localparam int BW    = be_width(DATA_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  v1;
  logic [DATA_WIDTH-1:0] d1;
  logic                  rd;

  assign rd = en && !we;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < BW; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read data only moves on a read, so it holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd;
      if (rd) d1 <= mem[addr];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                  v2;
    logic [DATA_WIDTH-1:0] d2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    end

    assign rvalid = v2;
    assign rdata  = d2;
  end else begin : g_noreg
    assign rvalid = v1;
    assign rdata  = d1;
  end

endmodule

// File: rtl/pixel_mem_bank_array.sv
// Multi-bank pixel line-buffer: zero-fill sweep FSM, grant logic and
// the mux between sweep writes and user accesses for every bank.
module pixel_mem_bank_array
  import pixel_mem_pkg::*;
#(
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_REG    = DEF_OUT_REG
) (
  input  logic                                            pixel_clk_i,
  input  logic                                            reset_n_i,
  input  logic                                            init_req_i,
  output logic                                            init_busy_o,
  input  logic [NUM_BANKS-1:0]                            req_i,
  input  logic [NUM_BANKS-1:0]                            we_i,
  input  logic [NUM_BANKS-1:0][be_width(DATA_WIDTH)-1:0]  be_i,
  input  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0]            addr_i,
  input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]            wdata_i,
  output logic [NUM_BANKS-1:0]                            gnt_o,
  output logic [NUM_BANKS-1:0]                            rvalid_o,
  output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]            rdata_o
);

  localparam int BW = be_width(DATA_WIDTH);

  mem_state_e          state, state_n;
  logic [ADDR_WIDTH:0] cnt, cnt_n, cnt_inc;
  logic                clearing;

  assign cnt_inc  = cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign clearing = (state == CLEAR);
  assign gnt_o    = req_i & {NUM_BANKS{state == READY}};

  always_ff @(posedge pixel_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= CLEAR;
      cnt         <= '0;
      init_busy_o <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      init_busy_o <= (state_n == CLEAR);
    end
  end

  // Extra counter bit flags the end of the sweep without wrapping.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      CLEAR: begin
        cnt_n = cnt_inc;
        if (cnt_inc[ADDR_WIDTH]) state_n = READY;
      end
      READY: begin
        if (init_req_i) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
    endcase
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                  en, we;
    logic [BW-1:0]         be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;

    always_comb begin
      en    = gnt_o[b];
      we    = we_i[b];
      be    = be_i[b];
      addr  = addr_i[b];
      wdata = wdata_i[b];
      if (clearing) begin
        en    = 1'b1;
        we    = 1'b1;
        be    = '1;
        addr  = cnt[ADDR_WIDTH-1:0];
        wdata = '0;
      end
    end

    pixel_mem_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_REG    (OUT_REG)
    ) u_bank (
      .clk    (pixel_clk_i),
      .rst_n  (reset_n_i),
      .en     (en),
      .we     (we),
      .be     (be),
      .addr   (addr),
      .wdata  (wdata),
      .rvalid (rvalid_o[b]),
      .rdata  (rdata_o[b])
    );
  end

endmodule

// File: tb/tb_pixel_mem_bank_array.sv
// Directed plus randomized bench for pixel_mem_bank_array against a
// word-array reference model with a due-cycle read-result queue.
module tb_pixel_mem_bank_array;

  localparam int NB    = 4;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int OR    = 0;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;
  localparam int L     = 1 + OR;

  logic                        pixel_clk_i;
  logic                        reset_n_i;
  logic                        init_req_i;
  logic                        init_busy_o;
  logic [NB-1:0]               req_i;
  logic [NB-1:0]               we_i;
  logic [NB-1:0][BW-1:0]       be_i;
  logic [NB-1:0][AW-1:0]       addr_i;
  logic [NB-1:0][DW-1:0]       wdata_i;
  logic [NB-1:0]               gnt_o;
  logic [NB-1:0]               rvalid_o;
  logic [NB-1:0][DW-1:0]       rdata_o;

  pixel_mem_bank_array #(
    .NUM_BANKS  (NB),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .OUT_REG    (OR)
  ) dut (
    .pixel_clk_i (pixel_clk_i),
    .reset_n_i   (reset_n_i),
    .init_req_i  (init_req_i),
    .init_busy_o (init_busy_o),
    .req_i       (req_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o)
  );

  initial pixel_clk_i = 1'b0;
  always #5 pixel_clk_i = ~pixel_clk_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] mem [NB][DEPTH];
  logic [63:0]   q [NB][$];
  logic [DW-1:0] exp_d [NB];
  int            rv_cnt [NB];
  logic          m_busy;
  int            m_cnt;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req_i      = '0;
    we_i       = '0;
    be_i       = '0;
    init_req_i = 1'b0;
  endtask

  task automatic model_reset();
    m_busy = 1'b1;
    m_cnt  = 0;
    for (int b = 0; b < NB; b++) begin
      q[b].delete();
      exp_d[b] = '0;
    end
  endtask

  // One clock: check grants and busy, update the model, check read results.
  task automatic step();
    logic        eg;
    logic        ev;
    logic [63:0] ent;
    logic [31:0] due;
    @(negedge pixel_clk_i);
    chk("busy", {31'b0, init_busy_o}, {31'b0, m_busy});
    for (int b = 0; b < NB; b++) begin
      eg = req_i[b] && !m_busy;
      chk($sformatf("gnt%0d", b), {31'b0, gnt_o[b]}, {31'b0, eg});
      if (eg && we_i[b]) begin
        for (int k = 0; k < BW; k++)
          if (be_i[b][k]) mem[b][addr_i[b]][k*8 +: 8] = wdata_i[b][k*8 +: 8];
      end else if (eg) begin
        due = cyc + L;
        q[b].push_back({due, mem[b][addr_i[b]]});
      end
    end
    if (m_busy) begin
      for (int b = 0; b < NB; b++) mem[b][m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_busy = 1'b0;
    end else if (init_req_i) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end
    @(posedge pixel_clk_i);
    cyc++;
    #1;
    for (int b = 0; b < NB; b++) begin
      ev = 1'b0;
      if (q[b].size() > 0) begin
        ent = q[b][0];
        if (ent[63:32] == cyc) begin
          ev = 1'b1;
          exp_d[b] = ent[31:0];
          void'(q[b].pop_front());
        end
      end
      chk($sformatf("rvalid%0d", b), {31'b0, rvalid_o[b]}, {31'b0, ev});
      chk($sformatf("rdata%0d", b), rdata_o[b], exp_d[b]);
      if (rvalid_o[b]) rv_cnt[b]++;
    end
  endtask

  task automatic wr(int b, logic [AW-1:0] a, logic [DW-1:0] d,
                    logic [BW-1:0] be);
    idle();
    req_i[b]   = 1'b1;
    we_i[b]    = 1'b1;
    be_i[b]    = be;
    addr_i[b]  = a;
    wdata_i[b] = d;
    step();
    idle();
  endtask

  task automatic read_wait(int b, logic [AW-1:0] a, logic [DW-1:0] exp,
                           string tag);
    int lat;
    idle();
    req_i[b]  = 1'b1;
    addr_i[b] = a;
    step();
    idle();
    lat = 1;
    while (!rvalid_o[b] && lat < 8) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, L);
    chk(tag, rdata_o[b], exp);
  endtask

  task automatic count_sweep(string tag, int hold_bank);
    int n;
    n = 0;
    while (init_busy_o && n < 2000) begin
      if (hold_bank >= 0) begin
        req_i[hold_bank]  = 1'b1;
        we_i[hold_bank]   = 1'b0;
        addr_i[hold_bank] = 8'h05;
      end
      step();
      n++;
    end
    idle();
    chk(tag, n, DEPTH);
  endtask

  initial begin
    int base;
    for (int b = 0; b < NB; b++) begin
      rv_cnt[b] = 0;
      for (int a = 0; a < DEPTH; a++) mem[b][a] = 'x;
    end
    idle();
    addr_i    = '0;
    wdata_i   = '0;
    reset_n_i = 1'b0;
    req_i     = '1;
    model_reset();
    repeat (2) @(posedge pixel_clk_i);
    #1;
    chk("rst_busy", {31'b0, init_busy_o}, 32'd1);
    chk("rst_gnt", {28'b0, gnt_o}, 32'd0);
    chk("rst_rvalid", {28'b0, rvalid_o}, 32'd0);
    chk("rst_rdata0", rdata_o[0], 32'd0);
    idle();
    reset_n_i = 1'b1;

    // Power-up sweep with a held request that must never be granted.
    count_sweep("sweep_len", 0);
    read_wait(0, 8'h00, 32'h0, "rd_zero_00");
    read_wait(0, 8'hFF, 32'h0, "rd_zero_ff");

    wr(1, 8'h10, 32'hDEADBEEF, 4'b1111);
    wr(1, 8'h10, 32'h11223344, 4'b0101);
    wr(1, 8'h10, 32'hFFFFFFFF, 4'b0000);
    read_wait(1, 8'h10, 32'hDE22BE44, "byte_en");

    for (int i = 0; i < 4; i++) wr(0, AW'(i), DW'(32'hA0 + i), 4'hF);
    base = rv_cnt[0];
    for (int i = 0; i < 4; i++) begin
      idle();
      req_i[0]  = 1'b1;
      addr_i[0] = AW'(i);
      step();
    end
    idle();
    repeat (L) step();
    chk("b2b_pulses", rv_cnt[0] - base, 4);

    for (int i = 0; i < 16; i++) wr(0, AW'(i), 32'h55555555, 4'hF);
    read_wait(0, 8'h05, 32'h55555555, "fill55");
    idle();
    init_req_i = 1'b1;
    step();
    idle();
    count_sweep("reinit_len", 0);
    read_wait(0, 8'h05, 32'h0, "post_init");

    // Reset in the middle of a sweep with non-zero read data on display.
    wr(2, 8'h07, 32'hCAFEF00D, 4'hF);
    read_wait(2, 8'h07, 32'hCAFEF00D, "pre_rst");
    init_req_i = 1'b1;
    step();
    idle();
    repeat (100) step();
    req_i     = '1;
    reset_n_i = 1'b0;
    #1;
    model_reset();
    chk("midrst_busy", {31'b0, init_busy_o}, 32'd1);
    chk("midrst_gnt", {28'b0, gnt_o}, 32'd0);
    chk("midrst_rvalid", {28'b0, rvalid_o}, 32'd0);
    chk("midrst_rdata2", rdata_o[2], 32'd0);
    repeat (2) @(posedge pixel_clk_i);
    #1;
    idle();
    reset_n_i = 1'b1;
    count_sweep("rst_sweep_len", -1);

    wr(2, 8'h09, 32'h12345678, 4'hF);
    wr(3, 8'h09, 32'h9ABCDEF0, 4'hF);
    idle();
    req_i      = 4'b1100;
    we_i       = 4'b0100;
    be_i[2]    = 4'hF;
    addr_i[2]  = 8'h09;
    addr_i[3]  = 8'h09;
    wdata_i[2] = 32'h0BADF00D;
    step();
    idle();
    repeat (L - 1) step();
    chk("indep_b3", rdata_o[3], 32'h9ABCDEF0);
    read_wait(2, 8'h09, 32'h0BADF00D, "indep_b2");

    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < NB; b++) begin
        req_i[b]   = ($urandom_range(0, 1) == 1);
        we_i[b]    = ($urandom_range(0, 1) == 1);
        be_i[b]    = BW'($urandom);
        addr_i[b]  = AW'($urandom_range(0, 15));
        wdata_i[b] = $urandom;
      end
      init_req_i = ($urandom_range(0, 299) == 0);
      step();
    end
    idle();
    repeat (L + 1) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
